// File: rtl/add4_seq_ctrl_if.sv
// Request/completion handshake plus the shared 4-bit adder hookup for add4_seq_ctrl.
// The master side is the requester together with the external adder.
interface add4_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         res_cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  modport master (
    output start, op_a, op_b, op_cin, add_sum, add_cout,
    input  busy, done, result, res_cout, add_a, add_b, add_cin
  );

  modport slave (
    input  start, op_a, op_b, op_cin, add_sum, add_cout,
    output busy, done, result, res_cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/add4_seq_ctrl.sv
// Nibble-serial wide adder sequencer driving one shared external 4-bit adder,
// least-significant nibble first, with a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start; adder inputs forced to 0
// S_RUN  | one nibble pair per cycle on the adder, carry chained
// S_DONE | one-cycle completion pulse, result already registered
module add4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  add4_seq_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sh_a, sh_b, acc, acc_nxt, result_q;
  logic [W+3:0]  acc_cat;
  logic          carry, res_cout_q;
  logic [CW-1:0] cnt;
  logic          last;

  assign last    = (cnt == CNT_LAST);
  // New sum nibble enters at the top so the LSB nibble ends up at the bottom.
  assign acc_cat = {bus.add_sum, acc};
  assign acc_nxt = acc_cat[W+3:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a       <= '0;
      sh_b       <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      result_q   <= '0;
      res_cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sh_a  <= bus.op_a;
            sh_b  <= bus.op_b;
            carry <= bus.op_cin;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          carry <= bus.add_cout;
          sh_a  <= sh_a >> 4;
          sh_b  <= sh_b >> 4;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result_q   <= acc_nxt;
            res_cout_q <= bus.add_cout;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.done     = (state == S_DONE);
    bus.result   = result_q;
    bus.res_cout = res_cout_q;
    bus.add_a    = 4'h0;
    bus.add_b    = 4'h0;
    bus.add_cin  = 1'b0;
    if (state == S_RUN) begin
      bus.add_a   = sh_a[3:0];
      bus.add_b   = sh_b[3:0];
      bus.add_cin = carry;
    end
  end
endmodule

// File: tb/tb_add4_seq_ctrl.sv
// Self-checking bench for add4_seq_ctrl: NIBBLES=4 and NIBBLES=1 instances,
// an arithmetic reference model, a per-cycle compare and directed literal checks.
module tb_add4_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        st[2];
  logic [15:0] oa[2], ob[2];
  logic        oc[2];
  logic        o_busy[2], o_done[2], o_cout[2], o_cin[2];
  logic [15:0] o_res[2];
  logic [3:0]  o_a[2], o_b[2];

  add4_seq_ctrl_if #(.NIBBLES(4)) if4 ();
  add4_seq_ctrl_if #(.NIBBLES(1)) if1 ();

  add4_seq_ctrl #(.NIBBLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  add4_seq_ctrl #(.NIBBLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if4.start  = st[0];
  assign if4.op_a   = oa[0];
  assign if4.op_b   = ob[0];
  assign if4.op_cin = oc[0];
  assign if1.start  = st[1];
  assign if1.op_a   = oa[1][3:0];
  assign if1.op_b   = ob[1][3:0];
  assign if1.op_cin = oc[1];

  // the shared external adders
  assign {if4.add_cout, if4.add_sum} = {1'b0, if4.add_a} + {1'b0, if4.add_b} + {4'b0, if4.add_cin};
  assign {if1.add_cout, if1.add_sum} = {1'b0, if1.add_a} + {1'b0, if1.add_b} + {4'b0, if1.add_cin};

  assign o_busy[0] = if4.busy;     assign o_busy[1] = if1.busy;
  assign o_done[0] = if4.done;     assign o_done[1] = if1.done;
  assign o_res[0]  = if4.result;   assign o_res[1]  = {12'h000, if1.result};
  assign o_cout[0] = if4.res_cout; assign o_cout[1] = if1.res_cout;
  assign o_a[0]    = if4.add_a;    assign o_a[1]    = if1.add_a;
  assign o_b[0]    = if4.add_b;    assign o_b[1]    = if1.add_b;
  assign o_cin[0]  = if4.add_cin;  assign o_cin[1]  = if1.add_cin;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: ph = cycles since the accepting edge (0 = idle).
  int          ph[2] = '{0, 0};
  logic [63:0] ma[2] = '{0, 0};
  logic [63:0] mb[2] = '{0, 0};
  logic [63:0] mc[2] = '{0, 0};
  logic [63:0] er[2] = '{0, 0};
  logic [63:0] ec[2] = '{0, 0};

  function automatic int nib(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] msk(input int i);
    return (64'd1 << (4 * nib(i))) - 64'd1;
  endfunction

  function automatic logic running(input int i);
    return (ph[i] >= 1) && (ph[i] <= nib(i));
  endfunction

  function automatic logic [63:0] nib_at(input logic [63:0] v, input int p);
    return (v >> (4 * (p - 1))) & 64'hF;
  endfunction

  // carry entering nibble k of the current operation
  function automatic logic [63:0] cin_at(input int i, input int k);
    logic [63:0] m;
    if (k == 0) return mc[i];
    m = (64'd1 << (4 * k)) - 64'd1;
    return (((ma[i] & m) + (mb[i] & m) + mc[i]) >> (4 * k)) & 64'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ph[i] <= 0;
        er[i] <= '0;
        ec[i] <= '0;
      end else if (ph[i] == 0) begin
        if (st[i]) begin
          ma[i] <= {48'h0, oa[i]} & msk(i);
          mb[i] <= {48'h0, ob[i]} & msk(i);
          mc[i] <= {63'h0, oc[i]};
          ph[i] <= 1;
        end
      end else if (ph[i] <= nib(i)) begin
        if (ph[i] == nib(i)) begin
          er[i] <= (ma[i] + mb[i] + mc[i]) & msk(i);
          ec[i] <= ((ma[i] + mb[i] + mc[i]) >> (4 * nib(i))) & 64'd1;
        end
        ph[i] <= ph[i] + 1;
      end else begin
        ph[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_busy", i), {63'h0, o_busy[i]}, {63'h0, ph[i] != 0});
      chk($sformatf("u%0d_done", i), {63'h0, o_done[i]}, {63'h0, ph[i] == nib(i) + 1});
      chk($sformatf("u%0d_result", i), {48'h0, o_res[i]}, er[i]);
      chk($sformatf("u%0d_res_cout", i), {63'h0, o_cout[i]}, ec[i]);
      chk($sformatf("u%0d_add_a", i), {60'h0, o_a[i]}, running(i) ? nib_at(ma[i], ph[i]) : 64'd0);
      chk($sformatf("u%0d_add_b", i), {60'h0, o_b[i]}, running(i) ? nib_at(mb[i], ph[i]) : 64'd0);
      chk($sformatf("u%0d_add_cin", i), {63'h0, o_cin[i]}, running(i) ? cin_at(i, ph[i] - 1) : 64'd0);
    end
  end

  // Present operands with start for one accepting edge; returns 2 time units after it.
  task automatic go(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(posedge clk); #2;
    oa[i] = a; ob[i] = b; oc[i] = c; st[i] = 1'b1;
    @(posedge clk); #2;
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (o_done[i]) break;
      if (cyc > 40) begin
        chk("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  logic [3:0]  seq_a[4];
  logic        seq_c[4];
  logic [3:0]  va[9], vb[9];
  logic        vc[9];
  logic [4:0]  vx[9];
  int          cyc;
  int          ndone;

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; oa[i] = '0; ob[i] = '0; oc[i] = 1'b0;
    end
    seq_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    seq_c = '{1'b0, 1'b1, 1'b1, 1'b1};
    va = '{4'h0, 4'h1, 4'h3, 4'h6, 4'h9, 4'hC, 4'hC, 4'hF, 4'hF};
    vb = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h6, 4'h3, 4'h3, 4'h5, 4'hA};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vx = '{5'h00, 5'h01, 5'h04, 5'h09, 5'h0F, 5'h0F, 5'h10, 5'h15, 5'h19};

    #12;
    chk("reset_busy", {63'h0, o_busy[0]}, 64'd0);
    chk("reset_result", {48'h0, o_res[0]}, 64'd0);
    #11 rst_n = 1'b1;

    // 1234 + 4321, nibble order and latency
    go(0, 16'h1234, 16'h4321, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_busy", {63'h0, o_busy[0]}, 64'd1);
      chk("t1_add_a", {60'h0, o_a[0]}, {60'h0, seq_a[k]});
      chk("t1_done_early", {63'h0, o_done[0]}, 64'd0);
    end
    @(negedge clk);
    chk("t1_done", {63'h0, o_done[0]}, 64'd1);
    chk("t1_result", {48'h0, o_res[0]}, 64'h5555);
    chk("t1_cout", {63'h0, o_cout[0]}, 64'd0);

    // result hold while idle
    @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      chk("t6_result", {48'h0, o_res[0]}, 64'h5555);
      chk("t6_busy", {63'h0, o_busy[0]}, 64'd0);
      chk("t6_add_a", {60'h0, o_a[0]}, 64'd0);
      chk("t6_add_b", {60'h0, o_b[0]}, 64'd0);
      chk("t6_add_cin", {63'h0, o_cin[0]}, 64'd0);
    end

    // carry ripple
    go(0, 16'hFFFF, 16'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_add_cin", {63'h0, o_cin[0]}, {63'h0, seq_c[k]});
    end
    @(negedge clk);
    chk("t2a_done", {63'h0, o_done[0]}, 64'd1);
    chk("t2a_result", {48'h0, o_res[0]}, 64'h0000);
    chk("t2a_cout", {63'h0, o_cout[0]}, 64'd1);
    go(0, 16'hFFFF, 16'h0000, 1'b1);
    wait_done(0, cyc);
    chk("t2b_result", {48'h0, o_res[0]}, 64'h0000);
    chk("t2b_cout", {63'h0, o_cout[0]}, 64'd1);

    // single-nibble instance
    for (int v = 0; v < 9; v++) begin
      go(1, {12'h000, va[v]}, {12'h000, vb[v]}, vc[v]);
      wait_done(1, cyc);
      chk($sformatf("t3_latency_%0d", v), cyc, 64'd2);
      chk($sformatf("t3_sum_%0d", v), {59'h0, o_cout[1], o_res[1][3:0]}, {59'h0, vx[v]});
    end

    // start held high with operands changing every cycle
    @(posedge clk); #2;
    st[0] = 1'b1;
    ndone = 0;
    repeat (31) begin
      @(negedge clk);
      if (o_done[0]) ndone++;
      oa[0] = 16'($urandom); ob[0] = 16'($urandom); oc[0] = 1'($urandom);
    end
    st[0] = 1'b0;
    chk("t4_done_count", ndone, 64'd5);
    repeat (8) @(negedge clk);

    // reset mid-run
    @(posedge clk); #2;
    oa[0] = 16'h00FF; ob[0] = 16'h0F0F; oc[0] = 1'b1; st[0] = 1'b1;
    @(posedge clk); #2;
    st[0] = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {63'h0, o_busy[0]}, 64'd0);
    chk("t5_done", {63'h0, o_done[0]}, 64'd0);
    chk("t5_result", {48'h0, o_res[0]}, 64'd0);
    chk("t5_cout", {63'h0, o_cout[0]}, 64'd0);
    chk("t5_add_a", {60'h0, o_a[0]}, 64'd0);
    chk("t5_add_cin", {63'h0, o_cin[0]}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done[0]) ndone++;
    end
    chk("t5_no_done", ndone, 64'd0);
    go(0, 16'h0001, 16'h0001, 1'b0);
    wait_done(0, cyc);
    chk("t5_latency", cyc, 64'd5);
    chk("t5_result_after", {48'h0, o_res[0]}, 64'h0002);
    chk("t5_cout_after", {63'h0, o_cout[0]}, 64'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
